// File: rtl/gate_sweep_checker_pkg.sv
// Shared types and constants for the gate sweep checker and its reference model.
// The optional GATE_SWEEP_ERRCNT_EN build adds a total mismatching-bit counter.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int NUM_GATES = 7;
    localparam int COMBO_W   = 2;
    localparam int CNT_W     = 4;
    localparam int ERR_W     = 5;

    localparam int GATE_NOT  = 0;
    localparam int GATE_AND  = 1;
    localparam int GATE_NAND = 2;
    localparam int GATE_OR   = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    function automatic logic [ERR_W-1:0] popcount_gates(input logic [NUM_GATES-1:0] v);
        logic [ERR_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            n = n + {{(ERR_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Gate drive/observe bus plus sweep request and result signals.
// err_count exists only when GATE_SWEEP_ERRCNT_EN is defined.
interface gate_sweep_if;
    import gate_sweep_pkg::*;

    logic                 start;
    logic                 drv_a;
    logic                 drv_b;
    logic [NUM_GATES-1:0] obs;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] fail_mask;
    logic [COMBO_W-1:0]   first_fail_combo;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [ERR_W-1:0]     err_count;
`endif

    // master = the checker; slave = the gate block / request side
    modport master (
`ifdef GATE_SWEEP_ERRCNT_EN
        output err_count,
`endif
        input  start, obs,
        output drv_a, drv_b, busy, done, pass, fail_mask, first_fail_combo
    );

    modport slave (
`ifdef GATE_SWEEP_ERRCNT_EN
        input  err_count,
`endif
        output start, obs,
        input  drv_a, drv_b, busy, done, pass, fail_mask, first_fail_combo
    );

endinterface

// File: rtl/gate_sweep_checker_ref.sv
// Combinational truth-table model of the seven-output two-input gate block.
module gate_sweep_ref
    import gate_sweep_pkg::*;
(
    input  logic                 a_i,
    input  logic                 b_i,
    output logic [NUM_GATES-1:0] exp_o
);

    always_comb begin
        exp_o            = '0;
        exp_o[GATE_NOT]  = ~a_i;
        exp_o[GATE_AND]  = a_i & b_i;
        exp_o[GATE_NAND] = ~(a_i & b_i);
        exp_o[GATE_OR]   = a_i | b_i;
        exp_o[GATE_NOR]  = ~(a_i | b_i);
        exp_o[GATE_XOR]  = a_i ^ b_i;
        exp_o[GATE_XNOR] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweep engine: drives the four {a,b} combos, samples obs after SETTLE_CYCLES and
// accumulates mismatches. GATE_SWEEP_ERRCNT_EN adds the mismatching-bit counter.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; results held
//   ST_SETTLE | drive stable, settle counter running down
//   ST_SAMPLE | compare obs against expected for current combo
//   ST_REPORT | done pulse, then back to idle
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_sweep_if.master  sweep_bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [COMBO_W-1:0] COMBO_LAST = '1;

    state_t               state_q, state_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [NUM_GATES-1:0] mask_q, mask_d;
    logic [COMBO_W-1:0]   ffc_q, ffc_d;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [ERR_W-1:0]     err_q, err_d;
`endif

    logic [NUM_GATES-1:0] exp_w;
    logic [NUM_GATES-1:0] mismatch_w;

    gate_sweep_ref u_ref (
        .a_i   (combo_q[1]),
        .b_i   (combo_q[0]),
        .exp_o (exp_w)
    );

    assign mismatch_w = sweep_bus.obs ^ exp_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            combo_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            ffc_q   <= '0;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            combo_q <= combo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            ffc_q   <= ffc_d;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        combo_d = combo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        ffc_d   = ffc_q;
`ifdef GATE_SWEEP_ERRCNT_EN
        err_d   = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sweep_bus.start) begin
                    combo_d = '0;
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                    ffc_d   = '0;
`ifdef GATE_SWEEP_ERRCNT_EN
                    err_d   = '0;
`endif
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                mask_d = mask_q | mismatch_w;
                // an all-zero mask so far means this is the first failing combo
                if (mismatch_w != '0 && mask_q == '0) begin
                    ffc_d = combo_q;
                end
`ifdef GATE_SWEEP_ERRCNT_EN
                err_d = err_q + popcount_gates(mismatch_w);
`endif
                if (combo_q == COMBO_LAST) begin
                    pass_d  = ~|(mask_q | mismatch_w);
                    done_d  = 1'b1;
                    state_d = ST_REPORT;
                end else begin
                    combo_d = combo_q + 1'b1;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_REPORT: begin
                combo_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sweep_bus.drv_a            = combo_q[1];
    assign sweep_bus.drv_b            = combo_q[0];
    assign sweep_bus.busy             = busy_q;
    assign sweep_bus.done             = done_q;
    assign sweep_bus.pass             = pass_q;
    assign sweep_bus.fail_mask        = mask_q;
    assign sweep_bus.first_fail_combo = ffc_q;
`ifdef GATE_SWEEP_ERRCNT_EN
    assign sweep_bus.err_count        = err_q;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: faulty gate models on the obs side,
// hand-computed results. Define GATE_SWEEP_ERRCNT_EN to also check err_count.
module tb_gate_sweep_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   fault1 = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    gate_sweep_if bus1 ();
    gate_sweep_if bus3 ();

    always #5 clk = ~clk;

    // 0 good, 1 AND stuck-at-0, 2 XOR/XNOR swapped, 3 NOR stuck-at-1
    function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
        logic [6:0] g;
        g = {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b, ~a};
        case (fault)
            1: g[1] = 1'b0;
            2: g = {g[5], g[6], g[4:0]};
            3: g[4] = 1'b1;
            default: ;
        endcase
        return g;
    endfunction

    assign bus1.obs = gate_model(bus1.drv_a, bus1.drv_b, fault1);
    assign bus3.obs = gate_model(bus3.drv_a, bus3.drv_b, 0);

    gate_sweep_checker #(.SETTLE_CYCLES(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sweep_bus (bus1)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sweep_bus (bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs1();
        return {19'd0, bus1.drv_a, bus1.drv_b, bus1.busy, bus1.done, bus1.pass,
                bus1.fail_mask, bus1.first_fail_combo};
    endfunction

    task automatic run_sweep(input string tag, input int fault, input logic [6:0] exp_mask,
                             input logic [1:0] exp_ffc, input logic exp_pass, input int exp_err);
        int n;
        fault1 = fault;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done_lat"}, n, 8);
        check({tag, "_mask"}, {25'd0, bus1.fail_mask}, {25'd0, exp_mask});
        check({tag, "_ffc"}, {30'd0, bus1.first_fail_combo}, {30'd0, exp_ffc});
        check({tag, "_pass"}, {31'd0, bus1.pass}, {31'd0, exp_pass});
`ifdef GATE_SWEEP_ERRCNT_EN
        check({tag, "_err"}, {27'd0, bus1.err_count}, exp_err);
`else
        if (exp_err < 0) $display("unexpected negative err %0d", exp_err);
`endif
        tick();
        check({tag, "_idle"}, {30'd0, bus1.busy, bus1.done}, 0);
    endtask

    initial begin
        int n;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        tick();
        tick();
        check("reset_outs", outs1(), 0);
        check("reset_outs3", {30'd0, bus3.busy, bus3.done}, 0);
        rst_n = 1'b1;
        tick();

        // good gates, 1-cycle start, plus a start pulse while busy
        bus1.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) bus1.start = 1'b0;
            if (i == 3) bus1.start = 1'b1;
            if (i == 4) bus1.start = 1'b0;
            check($sformatf("drv_seq%0d", i), {30'd0, bus1.drv_a, bus1.drv_b}, i / 2);
            check($sformatf("busy_seq%0d", i), {30'd0, bus1.busy, bus1.done}, 2);
        end
        tick();
        check("good_report", outs1(), {19'd0, 2'b11, 1'b1, 1'b1, 1'b1, 7'h00, 2'b00});
        tick();
        check("good_idle", outs1(), {19'd0, 2'b00, 1'b0, 1'b0, 1'b1, 7'h00, 2'b00});
        tick();

        run_sweep("and_sa0", 1, 7'b0000010, 2'b11, 1'b0, 1);
        run_sweep("xor_swap", 2, 7'b1100000, 2'b00, 1'b0, 8);
        run_sweep("nor_sa1", 3, 7'b0010000, 2'b01, 1'b0, 3);
        run_sweep("good2", 0, 7'h00, 2'b00, 1'b1, 0);

        // reset during settle of combo 2 with partial failures already recorded
        fault1 = 3;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst", outs1(), {19'd0, 2'b10, 1'b1, 1'b0, 1'b0, 7'b0010000, 2'b01});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst", outs1(), 0);
`ifdef GATE_SWEEP_ERRCNT_EN
        check("mid_rst_err", {27'd0, bus1.err_count}, 0);
`endif
        #3;
        rst_n = 1'b1;
        tick();
        run_sweep("post_rst", 0, 7'h00, 2'b00, 1'b1, 0);

        // start held high, SETTLE_CYCLES=3
        bus3.start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus3.done && n < 60);
        check("held_first_done", n, 17);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus3.done && n < 60);
            check($sformatf("held_period%0d", k), n, 18);
            check($sformatf("held_pass%0d", k), {31'd0, bus3.pass}, 1);
        end
        bus3.start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("held_stop", {30'd0, bus3.busy, bus3.done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check engine for the seven-output two-input gate block (NOT, AND, NAND, OR, NOR, XOR, XNOR). On `start`, it drives the four input combinations onto the gate block, samples the seven outputs after a programmable settle time, and compares them against the expected truth tables. It reports pass/fail, a per-gate failure mask and the first failing combination. It is the driving and observing end of the gate interface, used as on-chip self-test and as the bench-side checker.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the inputs are held before sampling. Range 1..15; 0 is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `start` in 1: sweep request, level-sampled in IDLE only.
- `drv_a` out 1: drives gate input a.
- `drv_b` out 1: drives gate input b.
- `obs` in 7: gate outputs. Bit 0 not(a), 1 and, 2 nand, 3 or, 4 nor, 5 xor, 6 xnor.
- `busy` out 1: high from the accept edge until leaving REPORT.
- `done` out 1: one-cycle pulse in REPORT.
- `pass` out 1: 1 when `fail_mask` is 0; valid from `done`.
- `fail_mask` out 7: per-gate mismatch, accumulated over the sweep.
- `first_fail_combo` out 2: {a,b} of the first mismatching combination; 0 if none.
- `err_count` out 5: only with GATE_SWEEP_ERRCNT_EN.

## Operation
- States: IDLE, SETTLE, SAMPLE, REPORT.
- IDLE, `start`=1: combo←0, drv←{0,0}, fail_mask←0, first_fail_combo←0, pass←0, settle counter←SETTLE_CYCLES−1, go to SETTLE.
- SETTLE: the counter decrements. At 0, go to SAMPLE. Drive is stable throughout.
- SAMPLE: compute mismatch = `obs` XOR expected(combo). Then:
  - fail_mask |= mismatch.
  - If mismatch≠0 and no earlier failure, latch first_fail_combo←combo.
  - If combo=3, go to REPORT and set pass←~|(fail_mask|mismatch).
  - Otherwise combo←combo+1, drv←next combo, reload the counter, go to SETTLE.
- Combo order is 00, 01, 10, 11, with `drv_a` as the MSB. combo is 2 bits; no wrap beyond 3.
- REPORT: `done`=1 for exactly one cycle, then go to IDLE. drv returns to {0,0} on the REPORT→IDLE edge.
- `start` outside IDLE is ignored. `start` held high gives back-to-back sweeps with one IDLE cycle between them.
- `pass`, `fail_mask` and `first_fail_combo` hold until the next accepted `start`.
- Reset values: drv_a=0, drv_b=0, busy=0, done=0, pass=0, fail_mask=0, first_fail_combo=0, err_count=0; state IDLE.
- `rst_n` low mid-sweep forces all outputs to their reset values immediately, asynchronously. No partial result is retained.

## Timing
- Each combination occupies SETTLE_CYCLES+1 cycles.
- `done` rises 4·(SETTLE_CYCLES+1) rising edges after the accept edge: 8 for the default.
- Sweep-to-sweep period with `start` held high: 4·(SETTLE_CYCLES+1)+2 cycles.
- All outputs are registered. `obs` is sampled only in SAMPLE; it is don't-care elsewhere.
- `busy` rises on the accept edge and falls on the REPORT→IDLE edge.

## Configuration
- GATE_SWEEP_ERRCNT_EN defined:
  - `err_count` port present. It counts total mismatching bits over the sweep (0..28).
  - It is cleared on accept, adds popcount(mismatch) in each SAMPLE, and is valid with `done`.
- Undefined: no `err_count` port and no counter logic. All other behaviour is identical.

## Structure
- Package `gate_sweep_pkg` holds:
  - the state enum;
  - gate bit-index constants GATE_NOT..GATE_XNOR (0..6);
  - NUM_GATES=7;
  - the combo width constant.
- Sub-module `gate_sweep_ref`: combinational expected-value model, a,b → 7-bit expected vector. It is shared with the bench scoreboard.
- Top level contains the FSM, settle counter, combo counter and result registers.

## Test plan
- Correct gate model, SETTLE_CYCLES=1, 1-cycle `start` → drv sequence 00,01,10,11, each held 2 cycles. `done` arrives 8 edges after accept with pass=1, fail_mask=7'h00, first_fail_combo=0.
- AND output stuck-at-0 → fail_mask=7'b0000010, first_fail_combo=2'b11, pass=0.
- XOR/XNOR outputs swapped → fail_mask=7'b1100000, first_fail_combo=2'b00.
- NOR stuck-at-1 with GATE_SWEEP_ERRCNT_EN → fail_mask=7'b0010000, first_fail_combo=2'b01, err_count=3.
- `rst_n` low during SETTLE of combo 2 → all outputs 0 the same cycle. After release, a new `start` completes a normal passing sweep.
- `start` held high, SETTLE_CYCLES=3 → `done` pulses every 18 cycles. `start` pulses while `busy` do not disturb the sweep.
